psum_ofifo: RTL and testbench

PSUM_OFIFO -- requirements
Module: psum_ofifo

---
 rtl/psum_ofifo_pkg.sv | 9 +
 rtl/psum_ofifo_fifo_col.sv | 61 ++++++
 rtl/psum_ofifo.sv | 55 +++++
 tb/tb_psum_ofifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/psum_ofifo_pkg.sv
// Shared project parameters for the mac_row / psum_ofifo datapath.
// Column count, partial-sum width and output FIFO depth live here so both blocks agree.
package psum_ofifo_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 8;

endpackage

// File: rtl/psum_ofifo_fifo_col.sv
// Single-column circular FIFO with first-word-fall-through head.
// A push into a full column is accepted only when a pop frees the slot in the same cycle.
module fifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam int aw = $clog2(depth);
    localparam logic [aw-1:0] ptr_one  = aw'(1);
    localparam logic [aw:0]   cnt_one  = (aw + 1)'(1);
    localparam logic [aw:0]   cnt_full = (aw + 1)'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [aw-1:0]      wptr;
    logic [aw-1:0]      rptr;
    logic [aw:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == cnt_full);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign dout    = mem[rptr];

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + ptr_one;
            if (do_pop)  rptr <= rptr + ptr_one;
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; clearing the pointers and count is enough to discard entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO collecting one partial-sum row per pop across col independent columns.
// Columns fill on their own schedule; a row pops only once every column holds an entry.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0] full;
    logic [col-1:0] empty;
    logic [col-1:0] drop;
    logic           pop;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo_col (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (pop),
            .din   (in[psum_bw*c +: psum_bw]),
            .dout  (out[psum_bw*c +: psum_bw]),
            .full  (full[c]),
            .empty (empty[c]),
            .drop  (drop[c])
        );
    end

    // Sticky: once any write is lost the row stream is corrupt until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     o_overflow <= 1'b0;
        else if (|drop) o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo against a queue-per-column reference model.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int W = COL * PSUM_BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_d;
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   out_d;
    logic           o_valid, o_full, o_ready, o_overflow;

    int errors = 0;
    int checks = 0;

    logic [PSUM_BW-1:0] mq [COL][$];
    bit                 m_ovf;

    psum_ofifo #(.col(COL), .psum_bw(PSUM_BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_d),
        .wr         (wr),
        .rd         (rd),
        .out        (out_d),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] make_row(input int base);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(base + c);
        return r;
    endfunction

    function automatic logic [W-1:0] bcast(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(v);
        return r;
    endfunction

    function automatic bit exp_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_out();
        logic [W-1:0] r = '0;
        for (int c = 0; c < COL; c++) if (mq[c].size() > 0) r[c*PSUM_BW +: PSUM_BW] = mq[c][0];
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < COL; c++) mq[c].delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
        bit pop_now = r && exp_valid();
        for (int c = 0; c < COL; c++) begin
            int n = mq[c].size();
            if (pop_now) void'(mq[c].pop_front());
            if (w[c]) begin
                if (n < DEPTH || pop_now) mq[c].push_back(d[c*PSUM_BW +: PSUM_BW]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, update model, return at the next falling edge.
    task automatic cycle(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
        wr = w; in_d = d; rd = r;
        @(posedge clk);
        model_step(w, d, r);
        @(negedge clk);
        wr = '0; rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; wr = '0; rd = 1'b0; in_d = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", o_overflow); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_broadcast();
        cycle(8'hFF, make_row(1), 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bcast_valid got=%0b exp=1", o_valid); end
        checks++; if (out_d !== make_row(1)) begin errors++; $display("FAIL bcast_out got=%h exp=%h", out_d, make_row(1)); end
        cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bcast_drain got=%0b exp=0", o_valid); end
    endtask

    task automatic test_skew();
        do_reset();
        for (int c = 0; c < COL; c++) begin
            cycle(COL'(1) << c, make_row(16'h0100), 1'b1);
            checks++;
            if (o_valid !== (c == COL - 1)) begin
                errors++; $display("FAIL skew_valid col=%0d got=%0b exp=%0b", c, o_valid, c == COL - 1);
            end
        end
        checks++; if (out_d !== make_row(16'h0100)) begin errors++; $display("FAIL skew_out got=%h exp=%h", out_d, make_row(16'h0100)); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= DEPTH + 1; k++) begin
            cycle(8'hFF, bcast(k), 1'b0);
            if (k == DEPTH) begin
                checks++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL ovf_full got=%0b/%0b exp=1/0", o_full, o_ready); end
                checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", o_overflow); end
            end
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", o_overflow); end
        for (int k = 1; k <= DEPTH; k++) begin
            checks++; if (out_d !== bcast(k)) begin errors++; $display("FAIL ovf_pop k=%0d got=%h exp=%h", k, out_d, bcast(k)); end
            cycle('0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_end got=%0b/%0b exp=0/1", o_valid, o_overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 0; k < DEPTH; k++) cycle(8'hFF, bcast(10 + k), 1'b0);
        cycle(8'hFF, bcast(99), 1'b1);
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fpp_full got=%0b exp=1", o_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%0b exp=0", o_overflow); end
        checks++; if (out_d !== bcast(11)) begin errors++; $display("FAIL fpp_head got=%h exp=%h", out_d, bcast(11)); end
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (out_d !== exp_out()) begin errors++; $display("FAIL fpp_drain k=%0d got=%h exp=%h", k, out_d, exp_out()); end
            cycle('0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%0b exp=0", o_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0 || o_full !== 1'b0) begin errors++; $display("FAIL empty_rd got=%0b/%0b exp=0/0", o_valid, o_full); end
        cycle(8'hFF, make_row(16'h0200), 1'b0);
        for (int i = 1; i <= 20; i++) begin
            logic [W-1:0] exp_head = exp_out();
            checks++; if (out_d !== exp_head) begin errors++; $display("FAIL b2b i=%0d got=%h exp=%h", i, out_d, exp_head); end
            cycle(8'hFF, make_row(16'h0200 + 16 * i), 1'b1);
        end
        checks++; if (out_d !== make_row(16'h0200 + 16 * 20)) begin errors++; $display("FAIL b2b_last got=%h exp=%h", out_d, make_row(16'h0200 + 16 * 20)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            for (int c = 0; c < COL; c++) d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
            cycle(COL'($urandom | $urandom), d, ($urandom_range(0, 3) != 0));
            checks++;
            if (o_valid !== exp_valid() || o_full !== exp_full() || o_ready !== !exp_full() || o_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_flags i=%0d got=%0b%0b%0b%0b exp=%0b%0b%0b%0b", i, o_valid, o_full, o_ready, o_overflow,
                         exp_valid(), exp_full(), !exp_full(), m_ovf);
            end
            if (exp_valid()) begin
                checks++; if (out_d !== exp_out()) begin errors++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, out_d, exp_out()); end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k <= DEPTH; k++) cycle(8'hFF, bcast(k), 1'b0);
        for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0b/%0b exp=1/1", o_valid, o_overflow); end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL mid_rst got=%0b/%0b exp=0/1", o_valid, o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%0b exp=0", o_overflow); end
        @(negedge clk);
        reset = 1'b1;
        cycle(8'hFF, make_row(5), 1'b0);
        checks++; if (o_valid !== 1'b1 || out_d !== make_row(5)) begin errors++; $display("FAIL mid_after got=%h exp=%h", out_d, make_row(5)); end
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; in_d = '0;
        model_clear();
        test_reset();
        test_broadcast();
        test_skew();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
